// File: rtl/ltpi_smb_channel_arbiter.sv
//----------------------------------------------------------------------------
// ltpi_smb_channel_arbiter
//
// Round-robin arbiter that hands a single LVDS SMBus relay engine to one of
// NUM_CH SMBus channels at a time. A grant lasts until the relay engine
// reports completion (done), the LTPI link drops (aligned low), or the grant
// has run for TIMEOUT_CYC cycles. The last two cases end with an abort pulse.
//
// Parameters
//   NUM_CH       number of channels (2..8)
//   TIMEOUT_CYC  maximum BUSY cycles per grant (2..65535)
//
// Ports
//   clk          single clock
//   reset_n      asynchronous active-low reset
//   aligned      LTPI link aligned; grants are issued only while high
//   req          per-channel request levels
//   done         one-cycle completion pulse from the relay engine
//   grant        one-hot current owner, zero when no owner
//   grant_idx    binary index of the current or last owner
//   start        one-cycle pulse on a new grant
//   abort        one-cycle pulse ordering the relay engine to release the bus
//   busy         high while a grant is held
//   timeout_cnt  saturating count of timeout aborts
//
// Build option
//   LTPI_SMB_ARB_STATS_EN  when defined, timeout_cnt counts timeout aborts
//                          (not link-loss aborts); otherwise it reads zero.
//----------------------------------------------------------------------------
`timescale 1ns/1ps

module ltpi_smb_channel_arbiter #(
    parameter int unsigned NUM_CH      = 6,
    parameter int unsigned TIMEOUT_CYC = 25000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              aligned,
    input  logic [NUM_CH-1:0] req,
    input  logic              done,
    output logic [NUM_CH-1:0] grant,
    output logic [2:0]        grant_idx,
    output logic              start,
    output logic              abort,
    output logic              busy,
    output logic [15:0]       timeout_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RELEASE
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
    localparam logic [2:0]  LAST_CH  = 3'(NUM_CH - 1);

    state_t            r_state;
    logic [NUM_CH-1:0] r_grant;
    logic [2:0]        r_grant_idx;
    logic              r_start;
    logic              r_abort;
    logic              r_busy;
    logic [15:0]       r_timer;
    logic              r_armed;

    logic [31:0]       w_last;
    logic              w_found_hi;
    logic              w_found_lo;
    logic [2:0]        w_idx_hi;
    logic [2:0]        w_idx_lo;
    logic              w_found;
    logic [2:0]        w_win;
    logic [NUM_CH-1:0] w_win_oh;
    logic              w_timeout_hit;

    // Round-robin: the lowest requester above the last owner wins; if there
    // is none, the lowest requester at or below it wins, so the last owner
    // itself comes last.
    always_comb begin
        w_last     = 32'(r_grant_idx);
        w_found_hi = 1'b0;
        w_found_lo = 1'b0;
        w_idx_hi   = '0;
        w_idx_lo   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (req[i] && (i > w_last) && !w_found_hi) begin
                w_found_hi = 1'b1;
                w_idx_hi   = 3'(i);
            end
            if (req[i] && (i <= w_last) && !w_found_lo) begin
                w_found_lo = 1'b1;
                w_idx_lo   = 3'(i);
            end
        end
        w_found  = w_found_hi | w_found_lo;
        w_win    = w_found_hi ? w_idx_hi : w_idx_lo;
        w_win_oh = {{(NUM_CH-1){1'b0}}, 1'b1} << w_win;
    end

    assign w_timeout_hit = (r_timer == TMO_LAST);

    // r_armed holds off grants on the first edge after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_grant_idx <= LAST_CH;
            r_start     <= 1'b0;
            r_abort     <= 1'b0;
            r_busy      <= 1'b0;
            r_timer     <= '0;
            r_armed     <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            r_start <= 1'b0;
            r_abort <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_armed && aligned && w_found) begin
                        r_grant     <= w_win_oh;
                        r_grant_idx <= w_win;
                        r_start     <= 1'b1;
                        r_busy      <= 1'b1;
                        r_timer     <= '0;
                        r_state     <= BUSY;
                    end
                end
                BUSY: begin
                    r_timer <= r_timer + 16'd1;
                    if (done || !aligned || w_timeout_hit) begin
                        // done outranks both link loss and timeout
                        r_abort <= !done;
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_state <= RELEASE;
                    end
                end
                RELEASE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef LTPI_SMB_ARB_STATS_EN
    logic        w_timeout_abort;
    logic [15:0] r_timeout_cnt;

    assign w_timeout_abort = (r_state == BUSY) && !done && aligned && w_timeout_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_timeout_cnt <= '0;
        end else if (w_timeout_abort && (r_timeout_cnt != 16'hFFFF)) begin
            r_timeout_cnt <= r_timeout_cnt + 16'd1;
        end
    end

    assign timeout_cnt = r_timeout_cnt;
`else
    assign timeout_cnt = '0;
`endif

    assign grant     = r_grant;
    assign grant_idx = r_grant_idx;
    assign start     = r_start;
    assign abort     = r_abort;
    assign busy      = r_busy;

endmodule

// File: tb/tb_ltpi_smb_channel_arbiter.sv
`timescale 1ns/1ps

module tb_ltpi_smb_channel_arbiter;

    localparam int NCH = 6;
    localparam int TMO = 20;

    logic        clk;
    logic        reset_n;
    logic        aligned;
    logic [5:0]  req;
    logic        done;
    logic [5:0]  grant;
    logic [2:0]  grant_idx;
    logic        start;
    logic        abort;
    logic        busy;
    logic [15:0] timeout_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference state: last owner index and expected timeout count.
    int          m_last = NCH - 1;
    logic [15:0] m_tcnt = '0;

    ltpi_smb_channel_arbiter #(
        .NUM_CH      (NCH),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .aligned     (aligned),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .start       (start),
        .abort       (abort),
        .busy        (busy),
        .timeout_cnt (timeout_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Winner = requester at the smallest forward distance from the last owner
    // (distance 1 is the next channel, distance NCH is the last owner itself).
    function automatic int rr_pick(input logic [5:0] r, input int last);
        int best;
        int bestd;
        int d;
        best  = -1;
        bestd = NCH + 1;
        for (int i = 0; i < NCH; i++) begin
            if (r[i]) begin
                d = (i - last + NCH) % NCH;
                if (d == 0) d = NCH;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    function automatic logic [15:0] tcnt_after_timeout(input logic [15:0] cur);
`ifdef LTPI_SMB_ARB_STATS_EN
        return (cur == 16'hFFFF) ? cur : cur + 16'd1;
`else
        return cur;
`endif
    endfunction

    // Invariants sampled every cycle outside reset.
    always @(negedge clk) begin
        if (reset_n) begin
            check("onehot0", 32'($onehot0(grant)), 32'd1);
            check("grant_only_busy", 32'(grant != '0), 32'(busy));
        end
    end

    task automatic apply_reset();
        reset_n = 1'b0;
        req     = '0;
        done    = 1'b0;
        aligned = 1'b1;
        @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_gidx", 32'(grant_idx), 32'(NCH - 1));
        check("rst_start", 32'(start), 32'd0);
        check("rst_abort", 32'(abort), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tcnt", 32'(timeout_cnt), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_grant", 32'(grant), 32'd0);
        m_last = NCH - 1;
        m_tcnt = '0;
    endtask

    // One grant from an IDLE cycle: request r, done in BUSY cycle 'hold'
    // (beyond TMO means never), link drop in BUSY cycle 'drop_at' (0 = none).
    // Returns at the negedge of the IDLE cycle that follows RELEASE.
    task automatic do_txn(input logic [5:0] r, input int hold, input int drop_at, input bit scramble);
        int         win;
        logic [5:0] one;
        logic [5:0] exp_g;
        bit         by_done;
        bit         by_drop;
        one     = 6'd1;
        req     = r;
        aligned = 1'b1;
        done    = 1'b0;
        win     = rr_pick(r, m_last);
        exp_g   = one << win;
        by_done = (hold <= TMO) && (drop_at == 0 || hold <= drop_at);
        by_drop = !by_done && (drop_at != 0) && (drop_at <= TMO);
        @(negedge clk);
        check("grant_new", 32'(grant), 32'(exp_g));
        check("start_new", 32'(start), 32'd1);
        check("gidx_new", 32'(grant_idx), 32'(win));
        check("busy_new", 32'(busy), 32'd1);
        for (int c = 1; c <= TMO; c++) begin
            if (c > 1) begin
                check("grant_hold", 32'(grant), 32'(exp_g));
                check("start_low", 32'(start), 32'd0);
                check("busy_hold", 32'(busy), 32'd1);
            end
            check("abort_busy", 32'(abort), 32'd0);
            if (scramble) req = 6'($urandom);
            if (c == drop_at) aligned = 1'b0;
            done = (c == hold);
            @(negedge clk);
            done = 1'b0;
            if (c == hold || c == drop_at) break;
        end
        if (!by_done && !by_drop) m_tcnt = tcnt_after_timeout(m_tcnt);
        check("rel_grant", 32'(grant), 32'd0);
        check("rel_busy", 32'(busy), 32'd0);
        check("rel_start", 32'(start), 32'd0);
        check("rel_abort", 32'(abort), 32'(!by_done));
        check("rel_gidx", 32'(grant_idx), 32'(win));
        check("rel_tcnt", 32'(timeout_cnt), 32'(m_tcnt));
        @(negedge clk);
        check("gap_grant", 32'(grant), 32'd0);
        check("gap_abort", 32'(abort), 32'd0);
        m_last = win;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        aligned = 1'b0;
        req     = '0;
        done    = 1'b0;

        apply_reset();

        // Two requesters from reset, then the other one after a minimal gap.
        do_txn(6'b000101, 5, 0, 1'b0);
        do_txn(6'b000101, 3, 0, 1'b0);

        // Fair rotation with every channel requesting.
        apply_reset();
        for (int k = 0; k < 7; k++) do_txn(6'b111111, 10, 0, 1'b0);

        // Timeout: no done ever.
        do_txn(6'b001000, 99, 0, 1'b0);
        // done coincides with the timeout cycle.
        do_txn(6'b001000, TMO, 0, 1'b0);

        // Link loss during BUSY, then grants held off until realigned.
        do_txn(6'b010000, 99, 3, 1'b0);
        req = 6'b110000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("blocked_grant", 32'(grant), 32'd0);
            check("blocked_start", 32'(start), 32'd0);
        end
        do_txn(6'b110000, 4, 0, 1'b0);

        // Reset asserted mid-BUSY.
        req     = 6'b000010;
        aligned = 1'b1;
        @(negedge clk);
        check("pre_rst_grant", 32'(grant), 32'(6'd1 << rr_pick(6'b000010, m_last)));
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_grant", 32'(grant), 32'd0);
        check("async_abort", 32'(abort), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_gidx", 32'(grant_idx), 32'(NCH - 1));
        m_last = NCH - 1;
        m_tcnt = '0;
        req    = 6'b101100;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("release_edge_grant", 32'(grant), 32'd0);
        do_txn(6'b101100, 6, 0, 1'b0);

        // Randomized grants with request churn while busy.
        for (int k = 0; k < 30; k++) begin
            do_txn(6'($urandom_range(1, 63)), int'($urandom_range(1, 24)), 0, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ltpi_smb_channel_arbiter.md
LTPI_SMB_CHANNEL_ARBITER -- requirements
Module: ltpi_smb_channel_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 6: number of SMBus channels sharing one LVDS SMBus relay engine (range 2..8).
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 25000: maximum cycles per grant (1 ms at 25 MHz), range 2..65535.
REQ-003 The block SHALL have port clk, input, 1: single clock for all logic (one clock; reset is asynchronous and active-low).
REQ-004 The block SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port aligned, input, 1: LTPI link aligned; arbitration is permitted only while high.
REQ-006 The block SHALL have port req, input, NUM_CH: per-channel request level, high while the channel has a pending SMBus transaction.
REQ-007 The block SHALL have port done, input, 1: single-cycle pulse from the relay engine signalling that the current transaction has completed (STOP relayed).
REQ-008 The block SHALL have port grant, output, NUM_CH: one-hot owner of the relay engine; all zeros means no owner.
REQ-009 The block SHALL have port grant_idx, output, 3: binary index of the current or last owner.
REQ-010 The block SHALL have port start, output, 1: single-cycle pulse on a new grant.
REQ-011 The block SHALL have port abort, output, 1: single-cycle pulse ordering the relay engine to release the bus.
REQ-012 The block SHALL have port busy, output, 1: high in state BUSY.
REQ-013 The block SHALL have port timeout_cnt, output, 16: saturating count of timeout aborts (see Configuration).

Function
REQ-014 The FSM SHALL have exactly the states IDLE, BUSY and RELEASE.
REQ-015 IDLE transition: if aligned=1 and req is nonzero, the FSM SHALL select a winner, register grant/grant_idx, pulse start for one cycle and enter BUSY on the next edge; latency from req high to grant high is 1 cycle.
REQ-016 Winner selection SHALL be round-robin: search begins at index grant_idx+1, wraps from NUM_CH-1 to 0, and grant_idx itself has lowest priority.
REQ-017 BUSY behaviour: grant SHALL be held stable, and deassertion of req by the owner SHALL be ignored.
REQ-018 BUSY timer: a 16-bit counter SHALL clear on entry to BUSY and increment each cycle in BUSY.
REQ-019 BUSY exit priority SHALL be, highest first: done -> RELEASE with no abort; else aligned=0 -> abort pulse, RELEASE; else counter = TIMEOUT_CYC-1 -> abort pulse, timeout_cnt+1, RELEASE.
REQ-020 Simultaneous done and timeout SHALL be treated as done: no abort and no count.
REQ-021 RELEASE SHALL clear grant to zero, keep grant_idx, and return to IDLE after exactly 1 cycle; the minimum gap between grants is therefore 1 idle cycle.
REQ-022 done received in IDLE or RELEASE SHALL be ignored.
REQ-023 aligned low in IDLE SHALL block grants, with pending req held off.
REQ-024 The invariant $onehot0(grant) SHALL hold at all times, and grant SHALL be nonzero only in BUSY.

Reset
REQ-025 While reset_n=0 the block SHALL be in IDLE with grant=0, grant_idx=NUM_CH-1 (so the first grant searches from channel 0), start=0, abort=0, busy=0, timer=0 and timeout_cnt=0.
REQ-026 Reset asserted mid-BUSY SHALL drop grant immediately (asynchronously) without an abort pulse.
REQ-027 Reset deassertion SHALL take effect on the next clk edge, with no grant possible in that same cycle.

Configuration
REQ-028 Macro LTPI_SMB_ARB_STATS_EN SHALL control the timeout statistics: when defined, timeout_cnt counts timeout aborts only (not link-loss aborts), saturating at 0xFFFF.
REQ-029 When LTPI_SMB_ARB_STATS_EN is undefined, timeout_cnt SHALL be tied to 0, no counter register SHALL be inferred, and the port SHALL still be present.

Verification
REQ-030 The bench SHALL cover: aligned=1, req=6'b000101 from reset -> grant=000001 the cycle after, start pulse; done -> RELEASE, then grant=000100 after a 1-cycle gap.
REQ-031 The bench SHALL cover: all six req held high with done every 10 cycles -> grant order 0,1,2,3,4,5,0, no channel skipped.
REQ-032 The bench SHALL cover: owner holds grant with no done, TIMEOUT_CYC=20 -> abort at the 20th BUSY cycle, grant cleared next cycle, timeout_cnt=1 (0 with macro off).
REQ-033 The bench SHALL cover: done and timeout in the same cycle -> no abort, timeout_cnt unchanged.
REQ-034 The bench SHALL cover: aligned dropped in BUSY -> abort pulse, timeout_cnt unchanged, no new grant until aligned=1.
REQ-035 The bench SHALL cover: reset_n pulsed low mid-BUSY -> grant=0 immediately, no abort, and the first grant afterwards goes to the lowest requesting index.
